// File: rtl/sample_frame_loader.sv
// sample_frame_loader: groups a valid/ready sample stream into double-buffered frames of 8
module sample_frame_loader #(
    parameter int WIDTH       = 16,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic                   frame_ack,
    output logic                   frame_valid,
    output logic [WIDTH-1:0]       a,
    output logic [WIDTH-1:0]       b,
    output logic [WIDTH-1:0]       c,
    output logic [WIDTH-1:0]       d,
    output logic [WIDTH-1:0]       e,
    output logic [WIDTH-1:0]       f,
    output logic [WIDTH-1:0]       g,
    output logic [WIDTH-1:0]       h,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    typedef enum logic {FILL, WAIT} state_t;

    state_t                 state_q;
    logic [2:0]             idx_q;
    logic [WIDTH-1:0]       fill_q [8];
    logic [WIDTH-1:0]       out_q [8];
    logic                   valid_q;
    logic [FRAME_CNT_W-1:0] cnt_q;

    assign in_ready    = (state_q == FILL) && !Rst;
    assign frame_valid = valid_q;
    assign frame_cnt   = cnt_q;
    assign a = out_q[0];
    assign b = out_q[1];
    assign c = out_q[2];
    assign d = out_q[3];
    assign e = out_q[4];
    assign f = out_q[5];
    assign g = out_q[6];
    assign h = out_q[7];

    // Fill buffer collects samples; a full buffer moves to the output slots when the held frame is released
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= FILL;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                fill_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else if (state_q == FILL) begin
            if (in_valid && idx_q != 3'd7) begin
                fill_q[idx_q] <= in_data;
                idx_q         <= idx_q + 3'd1;
                if (frame_ack) valid_q <= 1'b0;
            end else if (in_valid && (!valid_q || frame_ack)) begin
                for (int i = 0; i < 7; i++) out_q[i] <= fill_q[i];
                out_q[7] <= in_data;
                valid_q  <= 1'b1;
                cnt_q    <= cnt_q + FRAME_CNT_W'(1);
                idx_q    <= 3'd0;
            end else if (in_valid) begin
                fill_q[7] <= in_data;
                state_q   <= WAIT;
            end else if (frame_ack) begin
                valid_q <= 1'b0;
            end
        end else if (frame_ack) begin
            for (int i = 0; i < 8; i++) out_q[i] <= fill_q[i];
            cnt_q   <= cnt_q + FRAME_CNT_W'(1);
            idx_q   <= 3'd0;
            state_q <= FILL;
        end
    end
endmodule

// File: tb/tb_sample_frame_loader.sv
// tb_sample_frame_loader: directed vector and sequence checks for sample_frame_loader
module tb_sample_frame_loader;
    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] dat;
        logic        ack;
        logic        fv;
        logic        rdy;
        logic [15:0] ea;
        logic [15:0] eh;
        logic [7:0]  cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        frame_ack = 1'b0;
    logic        in_ready, frame_valid;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  frame_cnt;
    logic [15:0] s [8];
    int          passed = 0;
    int          total = 0;
    vec_t        vecs [$];

    assign s[0] = a;
    assign s[1] = b;
    assign s[2] = c;
    assign s[3] = d;
    assign s[4] = e;
    assign s[5] = f;
    assign s[6] = g;
    assign s[7] = h;

    always #5 clk = ~clk;

    sample_frame_loader dut (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .frame_ack(frame_ack), .frame_valid(frame_valid),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic r, input logic iv, input logic [15:0] dv, input logic ak);
        rst = r;
        in_valid = iv;
        in_data = dv;
        frame_ack = ak;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string name, input logic [15:0] base, input logic [15:0] stride);
        for (int i = 0; i < 8; i++) chk(name, {16'd0, s[i]}, {16'd0, base + stride * 16'(i)});
    endtask

    task automatic add(input logic r, iv, input logic [15:0] dv, input logic ak, fv, rdy,
                       input logic [15:0] ea, eh, input logic [7:0] cnt);
        vec_t v;
        v.rst = r; v.iv = iv; v.dat = dv; v.ack = ak;
        v.fv = fv; v.rdy = rdy; v.ea = ea; v.eh = eh; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 1, 16'(i), 0, 0, 1, 0, 0, 0);
        add(0, 1, 8, 0, 1, 1, 1, 8, 1);
        for (int i = 9; i <= 15; i++) add(0, 1, 16'(i), 0, 1, 1, 1, 8, 1);
        add(0, 1, 16, 0, 1, 0, 1, 8, 1);
        add(0, 1, 99, 0, 1, 0, 1, 8, 1);
        add(0, 0, 0, 1, 1, 1, 9, 16, 2);
        add(0, 0, 0, 1, 0, 1, 9, 16, 2);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].iv, vecs[i].dat, vecs[i].ack);
            chk($sformatf("vec%0d_fv", i), {31'd0, frame_valid}, {31'd0, vecs[i].fv});
            chk($sformatf("vec%0d_rdy", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
            chk($sformatf("vec%0d_a", i), {16'd0, a}, {16'd0, vecs[i].ea});
            chk($sformatf("vec%0d_h", i), {16'd0, h}, {16'd0, vecs[i].eh});
            chk($sformatf("vec%0d_cnt", i), {24'd0, frame_cnt}, {24'd0, vecs[i].cnt});
        end
        chk_frame("wait_frame", 9, 1);

        for (int i = 0; i < 8; i++) step(0, 1, 16'(30 + i), 0);
        chk("pre_ack_cnt", {24'd0, frame_cnt}, 3);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 16'hFFFF, i == 7);
            chk("ack_xfer_fv", {31'd0, frame_valid}, 1);
        end
        chk_frame("ack_xfer_frame", 16'hFFFF, 0);
        chk("ack_xfer_cnt", {24'd0, frame_cnt}, 4);
        step(0, 0, 0, 1);
        chk("ack_clear_fv", {31'd0, frame_valid}, 0);

        for (int i = 0; i < 16; i++) begin
            step(0, i % 2 == 0, (i % 2 == 0) ? 16'(100 + i / 2) : 16'hDEAD, 0);
            chk("toggle_fv", {31'd0, frame_valid}, {31'd0, i == 14 || i == 15});
        end
        chk_frame("toggle_frame", 100, 1);
        chk("toggle_cnt", {24'd0, frame_cnt}, 5);

        for (int i = 0; i < 5; i++) step(0, 1, 16'(50 + i), 0);
        rst = 1'b1;
        #1;
        chk("rst_rdy", {31'd0, in_ready}, 0);
        step(1, 1, 16'h77, 0);
        chk("rst_fv", {31'd0, frame_valid}, 0);
        chk("rst_cnt", {24'd0, frame_cnt}, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 16'(20 + i), 0);
        chk_frame("post_rst_frame", 20, 1);
        chk("post_rst_cnt", {24'd0, frame_cnt}, 1);

        step(1, 0, 0, 0);
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 8; j++) step(0, 1, 16'(k * 8 + j), 1);
            if (k == 254) chk("cnt_255", {24'd0, frame_cnt}, 255);
        end
        chk("cnt_wrap", {24'd0, frame_cnt}, 0);
        chk("wrap_fv", {31'd0, frame_valid}, 1);
        chk_frame("wrap_frame", 16'(255 * 8), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
